// File: rtl/stm1_pkg.sv
// STM-1 shared constants: frame geometry, default widths and the
// per-interleave column boundaries shared with bridgetx.
package stm1_pkg;

    localparam int WID_DFLT  = 8;
    localparam int RWID_DFLT = 4;
    localparam int CWID_DFLT = 7;
    localparam int SWID_DFLT = 2;

    localparam int ROW_MAX = 8;
    localparam int COL_MAX = 89;
    localparam int STS_MAX = 2;

    localparam int FRAME_BYTES = (ROW_MAX + 1) * (COL_MAX + 1) * (STS_MAX + 1);

    // Column boundaries in 90-column, 3-way interleaved space
    localparam int SOH_COL_LAST   = 2;
    localparam int AU4_COL_FIRST  = 3;
    localparam int AU4_PTR_ROW    = 3;
    localparam int VC4_POH_COL    = 3;
    localparam int VC4_POH_STS    = 0;
    localparam int TUG3_COL_FIRST = 4;

endpackage

// File: rtl/stm1_poscnt.sv
// STM-1 frame position cascade: sts -> col -> row -> multiframe.
// load forces position (0,0,0); a load on the natural last byte still counts the multiframe.
module stm1_poscnt
    import stm1_pkg::*;
#(
    parameter int RW = RWID_DFLT,
    parameter int CW = CWID_DFLT,
    parameter int SW = SWID_DFLT
) (
    input  logic          clk19,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic [SW-1:0] sts,
    output logic [1:0]    mfcnt,
    output logic          last
);

    localparam logic [RW-1:0] RLAST = RW'(ROW_MAX);
    localparam logic [CW-1:0] CLAST = CW'(COL_MAX);
    localparam logic [SW-1:0] SLAST = SW'(STS_MAX);

    logic swrap;
    logic cwrap;
    logic rwrap;

    assign swrap = (sts == SLAST);
    assign cwrap = (col == CLAST);
    assign rwrap = (row == RLAST);
    assign last  = swrap & cwrap & rwrap;

    // Advance the position cascade on enabled bytes, or reload to frame start
    always_ff @(posedge clk19 or posedge rst) begin
        if (rst) begin
            row   <= '0;
            col   <= '0;
            sts   <= '0;
            mfcnt <= 2'd0;
        end else if (load) begin
            row <= '0;
            col <= '0;
            sts <= '0;
            if (en && last) begin
                mfcnt <= mfcnt + 2'd1;
            end
        end else if (en) begin
            if (swrap) begin
                sts <= '0;
                if (cwrap) begin
                    col <= '0;
                    if (rwrap) begin
                        row   <= '0;
                        mfcnt <= mfcnt + 2'd1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end else begin
                sts <= sts + SW'(1);
            end
        end
    end

endmodule

// File: rtl/stm1_tx_timing.sv
// STM-1 transmit timing generator and registered line byte stage.
// Optional STM_FSYNC_EN: fsync_in reloads the frame position, flagging off-boundary slips.
module stm1_tx_timing
    import stm1_pkg::*;
#(
    parameter int WID  = WID_DFLT,
    parameter int RWID = RWID_DFLT,
    parameter int CWID = CWID_DFLT,
    parameter int SWID = SWID_DFLT
) (
    input  logic            clk19,
    input  logic            rst,
    input  logic            en,
    input  logic            fsync_in,
    output logic [RWID-1:0] row,
    output logic [CWID-1:0] col,
    output logic [SWID-1:0] sts,
    output logic [1:0]      mfcnt,
    output logic            frame_start,
    input  logic [WID-1:0]  datain,
    output logic [WID-1:0]  dataout,
    output logic            dvalid,
    output logic            fpos,
    output logic            fsync_slip
);

    logic last;
    logic load;

    stm1_poscnt #(
        .RW (RWID),
        .CW (CWID),
        .SW (SWID)
    ) u_pos (
        .clk19 (clk19),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .row   (row),
        .col   (col),
        .sts   (sts),
        .mfcnt (mfcnt),
        .last  (last)
    );

    assign frame_start = en && (row == '0) && (col == '0) && (sts == '0);

`ifdef STM_FSYNC_EN
    assign load = fsync_in;

    // Flag a sync reload that did not land on the natural frame wrap
    always_ff @(posedge clk19 or posedge rst) begin
        if (rst) begin
            fsync_slip <= 1'b0;
        end else begin
            fsync_slip <= fsync_in && !(en && last);
        end
    end
`else
    logic unused_fsync;

    assign load         = 1'b0;
    assign fsync_slip   = 1'b0;
    assign unused_fsync = fsync_in ^ last;
`endif

    // Register the bridgetx byte for the current position onto the line
    always_ff @(posedge clk19 or posedge rst) begin
        if (rst) begin
            dataout <= '0;
            dvalid  <= 1'b0;
            fpos    <= 1'b0;
        end else if (en) begin
            dataout <= datain;
            dvalid  <= 1'b1;
            fpos    <= frame_start;
        end else begin
            dvalid <= 1'b0;
            fpos   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stm1_tx_timing.sv
// Directed bench for stm1_tx_timing: vector table plus frame, reset and fsync sequences.
// Expectations for fsync follow whether STM_FSYNC_EN is defined.
module tb_stm1_tx_timing;

    logic       clk19;
    logic       rst;
    logic       en;
    logic       fsync_in;
    logic [3:0] row;
    logic [6:0] col;
    logic [1:0] sts;
    logic [1:0] mfcnt;
    logic       frame_start;
    logic [7:0] datain;
    logic [7:0] dataout;
    logic       dvalid;
    logic       fpos;
    logic       fsync_slip;

    int nvec = 0;
    int nmis = 0;

    stm1_tx_timing dut (
        .clk19       (clk19),
        .rst         (rst),
        .en          (en),
        .fsync_in    (fsync_in),
        .row         (row),
        .col         (col),
        .sts         (sts),
        .mfcnt       (mfcnt),
        .frame_start (frame_start),
        .datain      (datain),
        .dataout     (dataout),
        .dvalid      (dvalid),
        .fpos        (fpos),
        .fsync_slip  (fsync_slip)
    );

    initial clk19 = 1'b0;
    always #5 clk19 = ~clk19;

    typedef struct {
        logic       en;
        logic [7:0] din;
        logic [3:0] r;
        logic [6:0] c;
        logic [1:0] s;
        logic       fs;
        logic [7:0] dout;
        logic       dv;
        logic       fp;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk19);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        fsync_in = 1'b0;
        datain   = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_to(input int r, input int c, input int s);
        int n;
        n  = 0;
        en = 1'b1;
        #1;
        while (!(row == r && col == c && sts == s) && n < 2500) begin
            tick();
            n++;
        end
        chk($sformatf("reach_%0d_%0d_%0d", r, c, s), 32'(n < 2500), 32'd1);
    endtask

    task automatic chk_pos(input string nm, input int r, input int c, input int s);
        chk({nm, "_row"}, 32'(row), 32'(r));
        chk({nm, "_col"}, 32'(col), 32'(c));
        chk({nm, "_sts"}, 32'(sts), 32'(s));
    endtask

    initial begin
        int er, ec, es, em;
        int fs_cnt, poserr, fposerr, sliperr;
        logic pfs;

        // ---- reset state ----
        rst      = 1'b1;
        en       = 1'b0;
        fsync_in = 1'b0;
        datain   = 8'h00;
        #1;
        chk_pos("rst", 0, 0, 0);
        chk("rst_mfcnt", 32'(mfcnt), 32'd0);
        chk("rst_dataout", 32'(dataout), 32'd0);
        chk("rst_dvalid", 32'(dvalid), 32'd0);
        chk("rst_fpos", 32'(fpos), 32'd0);
        chk("rst_slip", 32'(fsync_slip), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // ---- vector table: en toggling, latency, hold ----
        tv[0]  = '{1'b0, 8'h33, 4'd0, 7'd0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 8'hA1, 4'd0, 7'd0, 2'd0, 1'b1, 8'hA1, 1'b1, 1'b1};
        tv[2]  = '{1'b1, 8'hB2, 4'd0, 7'd0, 2'd1, 1'b0, 8'hB2, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 8'hC3, 4'd0, 7'd0, 2'd2, 1'b0, 8'hB2, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 8'hD4, 4'd0, 7'd0, 2'd2, 1'b0, 8'hB2, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 8'hE5, 4'd0, 7'd0, 2'd2, 1'b0, 8'hE5, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 8'hF6, 4'd0, 7'd1, 2'd0, 1'b0, 8'hF6, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 8'h07, 4'd0, 7'd1, 2'd1, 1'b0, 8'hF6, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 8'h18, 4'd0, 7'd1, 2'd1, 1'b0, 8'h18, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 8'h29, 4'd0, 7'd1, 2'd2, 1'b0, 8'h29, 1'b1, 1'b0};
        tv[10] = '{1'b1, 8'h3A, 4'd0, 7'd2, 2'd0, 1'b0, 8'h3A, 1'b1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            en     = tv[i].en;
            datain = tv[i].din;
            #1;
            chk_pos($sformatf("v%0d", i), int'(tv[i].r), int'(tv[i].c), int'(tv[i].s));
            chk($sformatf("v%0d_fs", i), 32'(frame_start), 32'(tv[i].fs));
            tick();
            chk($sformatf("v%0d_dout", i), 32'(dataout), 32'(tv[i].dout));
            chk($sformatf("v%0d_dv", i), 32'(dvalid), 32'(tv[i].dv));
            chk($sformatf("v%0d_fpos", i), 32'(fpos), 32'(tv[i].fp));
        end

        // ---- four full frames ----
        do_reset();
        er = 0; ec = 0; es = 0; em = 0;
        fs_cnt = 0; poserr = 0; fposerr = 0;
        en = 1'b1;
        for (int cyc = 0; cyc <= 4 * 2430; cyc++) begin
            datain = 8'(cyc);
            #1;
            if (row != er || col != ec || sts != es || mfcnt != em) poserr++;
            if (cyc == 2429) chk_pos("last_byte", 8, 89, 2);
            if (frame_start) fs_cnt++;
            if (cyc % 2430 == 0) begin
                chk($sformatf("fs_at_%0d", cyc), 32'(frame_start), 32'd1);
                chk($sformatf("mf_at_%0d", cyc), 32'(mfcnt), 32'((cyc / 2430) % 4));
            end
            pfs = frame_start;
            tick();
            if (fpos !== pfs || dataout !== 8'(cyc)) fposerr++;
            if (es == 2) begin
                es = 0;
                if (ec == 89) begin
                    ec = 0;
                    if (er == 8) begin
                        er = 0;
                        em = (em + 1) % 4;
                    end else er++;
                end else ec++;
            end else es++;
        end
        chk("frame_start_count", 32'(fs_cnt), 32'd5);
        chk("frames_pos_errs", 32'(poserr), 32'd0);
        chk("frames_fpos_errs", 32'(fposerr), 32'd0);

        // ---- async reset mid-frame ----
        do_reset();
        datain = 8'h5A;
        run_to(8, 89, 2);
        tick();
        run_to(4, 50, 1);
        chk("pre_rst_mf", 32'(mfcnt), 32'd1);
        chk("pre_rst_dout", 32'(dataout), 32'h5A);
        rst = 1'b1;
        #1;
        chk_pos("arst", 0, 0, 0);
        chk("arst_mf", 32'(mfcnt), 32'd0);
        chk("arst_dout", 32'(dataout), 32'd0);
        chk("arst_dv", 32'(dvalid), 32'd0);
        tick();
        rst = 1'b0;
        en  = 1'b1;
        #1;
        chk_pos("post_rst", 0, 0, 0);
        chk("post_rst_fs", 32'(frame_start), 32'd1);
        tick();
        chk("post_rst_fpos", 32'(fpos), 32'd1);

        // ---- fsync behaviour ----
        do_reset();
        run_to(2, 10, 0);
        fsync_in = 1'b1;
        tick();
        fsync_in = 1'b0;
`ifdef STM_FSYNC_EN
        chk_pos("fs_mid", 0, 0, 0);
        chk("fs_mid_slip", 32'(fsync_slip), 32'd1);
`else
        chk_pos("fs_mid", 2, 10, 1);
        chk("fs_mid_slip", 32'(fsync_slip), 32'd0);
`endif
        chk("fs_mid_mf", 32'(mfcnt), 32'd0);
        tick();
        chk("fs_mid_slip_end", 32'(fsync_slip), 32'd0);
        run_to(8, 89, 2);
        fsync_in = 1'b1;
        tick();
        fsync_in = 1'b0;
        chk_pos("fs_wrap", 0, 0, 0);
        chk("fs_wrap_mf", 32'(mfcnt), 32'd1);
        chk("fs_wrap_slip", 32'(fsync_slip), 32'd0);
        run_to(0, 0, 1);
        en       = 1'b0;
        fsync_in = 1'b1;
        tick();
        fsync_in = 1'b0;
`ifdef STM_FSYNC_EN
        chk_pos("fs_en0", 0, 0, 0);
        chk("fs_en0_slip", 32'(fsync_slip), 32'd1);
`else
        chk_pos("fs_en0", 0, 0, 1);
        chk("fs_en0_slip", 32'(fsync_slip), 32'd0);
`endif
        chk("fs_en0_mf", 32'(mfcnt), 32'd1);

`ifndef STM_FSYNC_EN
        // fsync pulses scattered over free-running counting change nothing
        do_reset();
        er = 0; ec = 0; es = 0;
        poserr = 0; sliperr = 0;
        en = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            fsync_in = (cyc % 37 == 5);
            #1;
            if (row != er || col != ec || sts != es) poserr++;
            tick();
            if (fsync_slip !== 1'b0) sliperr++;
            if (es == 2) begin
                es = 0;
                if (ec == 89) begin
                    ec = 0;
                    er = (er == 8) ? 0 : er + 1;
                end else ec++;
            end else es++;
        end
        fsync_in = 1'b0;
        chk("ign_fsync_pos_errs", 32'(poserr), 32'd0);
        chk("ign_fsync_slip_errs", 32'(sliperr), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
